hazard_mem_sequencer: RTL and testbench

- Issue/hazard controller between the decode stage (driven by the control unit's wreg/rmem/wmem decode) and the execute/memory stage of the CPU pipeline.
- Keeps a per-register write-pending scoreboard, stalls decode on RAW hazards and flushes decode on a taken branch.
- Sequences every data-memory access through a req/ready handshake with a timeout, holding the pipeline until the access completes.

---
 rtl/cpu_ctrl_pkg.sv | 6 +
 rtl/reg_scoreboard.sv | 35 +++
 rtl/hazard_mem_sequencer.sv | 76 +++++++
 tb/tb_hazard_mem_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state type and default sizing for the decode/memory hazard controller
package cpu_ctrl_pkg;
    typedef enum logic {IDLE, MEM_WAIT} mem_state_t;
    localparam int DEF_REG_AW  = 4;
    localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register write-pending bits with write-first read bypass and optional r0 mask
module reg_scoreboard #(
    parameter int AW      = 4,
    parameter bit ZERO_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          abt_en,
    input  logic [AW-1:0] abt_idx,
    input  logic [AW-1:0] rd1_idx,
    input  logic [AW-1:0] rd2_idx,
    output logic          rd1_pend,
    output logic          rd2_pend
);
    localparam int N = 2**AW;
    logic [N-1:0] pend, set_v, clr_v;
    always_comb begin
        set_v = '0;
        clr_v = '0;
        set_v[set_idx] = set_en & ~(ZERO_EN && set_idx == '0);
        clr_v[clr_idx] = clr_en;
        clr_v[abt_idx] = clr_v[abt_idx] | abt_en;
        // a writeback landing this cycle already satisfies the reader
        rd1_pend = pend[rd1_idx] & ~(clr_en && clr_idx == rd1_idx) & ~(ZERO_EN && rd1_idx == '0);
        rd2_pend = pend[rd2_idx] & ~(clr_en && clr_idx == rd2_idx) & ~(ZERO_EN && rd2_idx == '0);
    end
    // set after clear: the newly issued writer is younger than the one retiring
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pend <= '0;
        else pend <= (pend & ~clr_v) | set_v;
endmodule

// File: rtl/hazard_mem_sequencer.sv
// hazard_mem_sequencer: decode issue/stall/flush control with RAW scoreboard and timed memory handshake
module hazard_mem_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter bit ZERO_REG_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wreg,
    input  logic              id_rmem,
    input  logic              id_wmem,
    input  logic              ex_branch_taken,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_ready,
    output logic              issue,
    output logic              stall,
    output logic              flush_id,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_done,
    output logic              mem_err,
    output logic [15:0]       stall_cnt
);
    mem_state_t state, state_nx;
    logic [7:0] timer;
    logic we_q, wreg_q, hz1, hz2, hazard, timeout;
    logic [REG_AW-1:0] ld_rd;
    reg_scoreboard #(.AW(REG_AW), .ZERO_EN(ZERO_REG_EN)) u_sb (
        .clk(clk), .rst_n(rst_n),
        .set_en(issue & id_wreg), .set_idx(id_rd),
        .clr_en(wb_valid), .clr_idx(wb_rd),
        .abt_en(mem_err & ~we_q & wreg_q), .abt_idx(ld_rd),
        .rd1_idx(id_rs1), .rd2_idx(id_rs2),
        .rd1_pend(hz1), .rd2_pend(hz2)
    );
    always_comb begin
        hazard   = (id_rs1_used & hz1) | (id_rs2_used & hz2);
        mem_req  = state == MEM_WAIT;
        issue    = id_valid & ~hazard & ~ex_branch_taken & ~mem_req;
        stall    = ~ex_branch_taken & ((id_valid & hazard) | mem_req);
        flush_id = ex_branch_taken;
        mem_we   = mem_req & we_q;
        timeout  = mem_req & (timer == 8'(TIMEOUT - 1));
        mem_done = mem_req & mem_ready;
        mem_err  = timeout & ~mem_ready;
        state_nx = mem_req ? ((mem_done | mem_err) ? IDLE : MEM_WAIT)
                           : ((issue & (id_rmem | id_wmem)) ? MEM_WAIT : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            we_q      <= 1'b0;
            wreg_q    <= 1'b0;
            ld_rd     <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            timer <= mem_req ? timer + 8'd1 : 8'd0;
            if (issue) begin
                we_q   <= id_wmem;
                wreg_q <= id_wreg;
                ld_rd  <= id_rd;
            end
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
endmodule

// File: tb/tb_hazard_mem_sequencer.sv
// tb_hazard_mem_sequencer: directed and random checks of hazard_mem_sequencer against a cycle-level model
module tb_hazard_mem_sequencer;
    localparam int AW = 4;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_rs1_used, id_rs2_used, id_wreg, id_rmem, id_wmem, ex_branch_taken, wb_valid, mem_ready;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic issue, stall, flush_id, mem_req, mem_we, mem_done, mem_err;
    logic [15:0] stall_cnt;
    logic z_issue, z_stall, z_flush_id, z_mem_req, z_mem_we, z_mem_done, z_mem_err;
    logic [15:0] z_stall_cnt;
    int total = 0, bad = 0;
    bit pend[16];
    bit busy, st_we, st_w;
    int cnt, st_rd, scnt;
    bit e_issue, e_stall, e_done, e_err;

    always #5 clk = ~clk;

    hazard_mem_sequencer #(.REG_AW(AW), .TIMEOUT(TO), .ZERO_REG_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wreg(id_wreg),
        .id_rmem(id_rmem), .id_wmem(id_wmem), .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .mem_ready(mem_ready), .issue(issue), .stall(stall), .flush_id(flush_id),
        .mem_req(mem_req), .mem_we(mem_we), .mem_done(mem_done), .mem_err(mem_err), .stall_cnt(stall_cnt));

    hazard_mem_sequencer #(.REG_AW(AW), .TIMEOUT(TO), .ZERO_REG_EN(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wreg(id_wreg),
        .id_rmem(id_rmem), .id_wmem(id_wmem), .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .mem_ready(mem_ready), .issue(z_issue), .stall(z_stall), .flush_id(z_flush_id),
        .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_done(z_mem_done), .mem_err(z_mem_err), .stall_cnt(z_stall_cnt));

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pd(int r);
        return r != 0 && pend[r] && !(wb_valid && int'(wb_rd) == r);
    endfunction

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        busy = 0; cnt = 0; scnt = 0; st_we = 0; st_w = 0; st_rd = 0;
    endtask

    task automatic model_eval();
        bit haz;
        haz = (id_rs1_used && pd(int'(id_rs1))) || (id_rs2_used && pd(int'(id_rs2)));
        e_issue = id_valid && !haz && !ex_branch_taken && !busy;
        e_stall = !ex_branch_taken && ((id_valid && haz) || busy);
        e_done  = busy && mem_ready;
        e_err   = busy && !mem_ready && (cnt + 1 == TO);
    endtask

    task automatic model_step();
        if (wb_valid) pend[wb_rd] = 1'b0;
        if (e_err && !st_we && st_w) pend[st_rd] = 1'b0;
        if (e_issue && id_wreg && id_rd != 0) pend[id_rd] = 1'b1;
        if (e_stall && scnt < 65535) scnt++;
        if (busy) begin
            if (e_done || e_err) busy = 0;
            else cnt++;
        end else if (e_issue && (id_rmem || id_wmem)) begin
            busy = 1; cnt = 0; st_we = id_wmem; st_w = id_wreg; st_rd = int'(id_rd);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; id_rd = 0;
        id_wreg = 0; id_rmem = 0; id_wmem = 0; ex_branch_taken = 0; wb_valid = 0; wb_rd = 0; mem_ready = 0;
    endtask

    task automatic dec(int rs1, bit u1, int rs2, bit u2, int rd, bit w, bit rm, bit wm);
        id_valid = 1; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2); id_rs2_used = u2;
        id_rd = AW'(rd); id_wreg = w; id_rmem = rm; id_wmem = wm;
    endtask

    task automatic mid();
        #4;
        model_eval();
        chk("issue", issue, e_issue);
        chk("stall", stall, e_stall);
        chk("flush_id", flush_id, ex_branch_taken);
        chk("mem_req", mem_req, busy);
        chk("mem_we", mem_we, busy && st_we);
        chk("mem_done", mem_done, e_done);
        chk("mem_err", mem_err, e_err);
        chk("stall_cnt", stall_cnt, 16'(scnt));
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc();
        mid();
        edge_step();
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_issue", issue, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        cyc();
        // RAW stall then same-cycle writeback bypass
        dec(1, 1, 2, 1, 3, 1, 0, 0); mid(); chk("raw_first_issue", issue, 1); edge_step();
        dec(3, 1, 0, 0, 4, 1, 0, 0); mid(); chk("raw_stall", stall, 1); chk("raw_no_issue", issue, 0); edge_step();
        wb_valid = 1; wb_rd = 3;
        mid(); chk("raw_cnt", stall_cnt, 1); chk("raw_bypass_issue", issue, 1); edge_step();
        // zero register
        idle(); dec(0, 0, 0, 0, 0, 1, 0, 0); wb_valid = 1; wb_rd = 4; cyc();
        idle(); dec(0, 1, 0, 0, 0, 0, 0, 0);
        mid(); chk("zero_no_stall", stall, 0); chk("zero_off_stall", z_stall, 1); edge_step();
        idle(); wb_valid = 1; wb_rd = 0; cyc();
        // branch flush with hazard present
        idle(); dec(0, 0, 0, 0, 3, 1, 0, 0); cyc();
        idle(); dec(3, 1, 0, 0, 7, 1, 0, 0); ex_branch_taken = 1;
        mid(); chk("br_flush", flush_id, 1); chk("br_stall", stall, 0); chk("br_issue", issue, 0); edge_step();
        idle(); dec(7, 1, 0, 0, 0, 0, 0, 0); mid(); chk("br_no_set", stall, 0); edge_step();
        idle(); dec(3, 1, 0, 0, 0, 0, 0, 0); mid(); chk("br_keep_pend", stall, 1); edge_step();
        idle(); wb_valid = 1; wb_rd = 3; cyc();
        // load handshake, 4 cycles
        idle(); dec(0, 0, 0, 0, 5, 1, 1, 0); cyc();
        idle();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            mid();
            chk("ld_req", mem_req, 1); chk("ld_we", mem_we, 0); chk("ld_stall", stall, 1);
            chk("ld_done", mem_done, i == 3);
            edge_step();
        end
        idle(); dec(5, 1, 0, 0, 0, 0, 0, 0); mid(); chk("ld_pend", stall, 1); chk("ld_idle", mem_req, 0); edge_step();
        wb_valid = 1; wb_rd = 5; mid(); chk("ld_wb_issue", issue, 1); edge_step();
        // load timeout
        idle(); dec(0, 0, 0, 0, 6, 1, 1, 0); cyc();
        idle();
        for (int i = 0; i < TO; i++) begin
            mid(); chk("to_err", mem_err, i == TO - 1); chk("to_done", mem_done, 0); edge_step();
        end
        dec(6, 1, 0, 0, 0, 0, 0, 0); mid(); chk("to_pend_clr", stall, 0); chk("to_idle", issue, 1); edge_step();
        // store with ready on the timeout cycle
        idle(); dec(0, 0, 0, 0, 0, 0, 1, 1); cyc();
        idle();
        for (int i = 0; i < TO; i++) begin
            mem_ready = (i == TO - 1);
            mid(); chk("st_we", mem_we, 1); chk("st_done", mem_done, i == TO - 1); chk("st_err", mem_err, 0); edge_step();
        end
        idle(); cyc();
        // random traffic
        for (int n = 0; n < 500; n++) begin
            idle();
            id_valid = $urandom_range(0, 3) != 0;
            id_rs1 = AW'($urandom); id_rs2 = AW'($urandom); id_rd = AW'($urandom);
            id_rs1_used = $urandom_range(0, 1); id_rs2_used = $urandom_range(0, 1);
            id_wreg = $urandom_range(0, 2) != 0;
            id_rmem = $urandom_range(0, 4) == 0; id_wmem = $urandom_range(0, 4) == 0;
            ex_branch_taken = !busy && $urandom_range(0, 9) == 0;
            wb_valid = $urandom_range(0, 2) == 0; wb_rd = AW'($urandom);
            mem_ready = $urandom_range(0, 2) == 0;
            cyc();
        end
        // reset in the middle of an access
        idle(); wb_valid = 1; wb_rd = 9; cyc();
        idle(); dec(0, 0, 0, 0, 9, 1, 0, 0); cyc();
        idle(); dec(0, 0, 0, 0, 10, 1, 1, 0); cyc();
        idle(); cyc();
        #4;
        rst_n = 0;
        #1;
        chk("mrst_req", mem_req, 0); chk("mrst_cnt", stall_cnt, 0);
        chk("mrst_done", mem_done, 0); chk("mrst_err", mem_err, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        dec(9, 1, 10, 1, 0, 0, 0, 0); mid(); chk("mrst_issue", issue, 1); chk("mrst_stall", stall, 0); edge_step();
        idle(); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
